// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared widths, loader FSM states and instruction type
package instr_mem_loader_pkg;
    localparam int instr_width_c = 32;
    localparam int addr_width_c = 10;
    typedef enum logic {IDLE, LOAD} load_state_e;
    typedef struct packed {
        logic [instr_width_c-1:0] word;
    } instruction_s;
endpackage

// File: rtl/imem_ram_1r1w.sv
// imem_ram_1r1w: synchronous array, one write port, one registered read port with hold
module imem_ram_1r1w
    import instr_mem_loader_pkg::*;
#(
    parameter int addr_width_p = addr_width_c,
    parameter int width_p = instr_width_c
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    we,
    input  logic [addr_width_p-1:0] waddr,
    input  logic [width_p-1:0]      wdata,
    input  logic                    re,
    input  logic [addr_width_p-1:0] raddr,
    output logic [width_p-1:0]      rdata
);
    logic [width_p-1:0] mem [2**addr_width_p];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory with stallable fetch port and streaming burst loader
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int addr_width_p = addr_width_c,
    parameter int instr_width_p = instr_width_c
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fetch_en_i,
    input  logic [addr_width_p-1:0]  fetch_addr_i,
    output logic [instr_width_p-1:0] instruction_o,
    output logic                     fetch_valid_o,
    input  logic                     load_start_i,
    input  logic [addr_width_p-1:0]  load_base_i,
    input  logic [addr_width_p:0]    load_len_i,
    input  logic                     load_valid_i,
    input  logic [instr_width_p-1:0] load_data_i,
    output logic                     load_ready_o,
    output logic                     load_done_o,
    output logic                     busy_o
);
    load_state_e state, state_n;
    logic [addr_width_p-1:0] ptr;
    logic [addr_width_p:0] remaining;
    logic start, accept, last, fetch_acc;
    assign load_ready_o = (state == LOAD);
    assign busy_o = load_ready_o;
    assign start = (state == IDLE) && load_start_i;
    assign accept = load_valid_i && load_ready_o;
    assign last = accept && (remaining == (addr_width_p+1)'(1));
    assign fetch_acc = fetch_en_i && (state == IDLE) && !load_start_i;
    always_comb begin
        state_n = state;
        if (start && load_len_i != '0) state_n = LOAD;
        else if (last) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr <= '0;
            remaining <= '0;
            load_done_o <= 1'b0;
            fetch_valid_o <= 1'b0;
        end else begin
            state <= state_n;
            load_done_o <= (start && load_len_i == '0) || last;
            // A load start in IDLE drops any concurrent fetch.
            fetch_valid_o <= (state == LOAD || load_start_i) ? 1'b0 : (fetch_en_i ? 1'b1 : fetch_valid_o);
            if (start && load_len_i != '0) begin
                ptr <= load_base_i;
                remaining <= load_len_i;
            end else if (accept) begin
                ptr <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
        end
    end
    imem_ram_1r1w #(.addr_width_p(addr_width_p), .width_p(instr_width_p)) u_ram (
        .clk(clk),
        .reset_n(reset_n),
        .we(accept && reset_n),
        .waddr(ptr),
        .wdata(load_data_i),
        .re(fetch_acc),
        .raddr(fetch_addr_i),
        .rdata(instruction_o)
    );
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: scoreboard bench for load bursts, fetch, stall, collisions and reset
module tb_instr_mem_loader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic fetch_en = 1'b0;
    logic [9:0] fetch_addr = '0;
    logic [31:0] instruction;
    logic fetch_valid;
    logic load_start = 1'b0;
    logic [9:0] load_base = '0;
    logic [10:0] load_len = '0;
    logic load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic load_ready, load_done, busy;
    int passed = 0;
    int total = 0;
    logic [31:0] model [1024];
    logic [31:0] exp_q [$];

    instr_mem_loader dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_en_i(fetch_en), .fetch_addr_i(fetch_addr),
        .instruction_o(instruction), .fetch_valid_o(fetch_valid),
        .load_start_i(load_start), .load_base_i(load_base), .load_len_i(load_len),
        .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(load_ready), .load_done_o(load_done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && load_start && !busy)
            assert (load_len <= 11'd1024) else $error("illegal load_len %0d", load_len);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int addr);
        fetch_en = 1'b1;
        fetch_addr = 10'(addr);
        exp_q.push_back(model[addr]);
        step();
        fetch_en = 1'b0;
        check("fetch_data", instruction, exp_q.pop_front());
        check("fetch_valid", fetch_valid, 1);
    endtask

    task automatic load_burst(input int base, input int len, input logic [31:0] seed,
                              input bit gaps, input bit collide);
        int n = 0;
        int cyc = 0;
        fetch_en = collide;
        fetch_addr = 10'd4;
        load_start = 1'b1;
        load_base = 10'(base);
        load_len = 11'(len);
        step();
        load_start = 1'b0;
        fetch_en = 1'b0;
        if (collide) check("collide_fetch_valid", fetch_valid, 0);
        if (len == 0) begin
            check("zero_done", load_done, 1);
            check("zero_busy", busy, 0);
        end else begin
            check("start_busy", busy, 1);
            while (n < len && cyc < 4 * len + 10) begin
                check("load_ready", load_ready, 1);
                load_valid = gaps ? (cyc < 4 ? (cyc % 2 == 0) : 1'b1) : 1'b1;
                load_data = seed + 32'(n);
                if (load_valid) begin
                    model[(base + n) % 1024] = load_data;
                    n++;
                end
                step();
                cyc++;
                check("done_timing", load_done, n == len);
            end
            load_valid = 1'b0;
            check("load_count", n, len);
            check("done_busy", busy, 0);
        end
        step();
        check("done_one_cycle", load_done, 0);
    endtask

    initial begin
        fetch_en = 1'b1;
        step();
        step();
        check("rst_instr", instruction, 0);
        check("rst_valid", fetch_valid, 0);
        check("rst_ready", load_ready, 0);
        check("rst_busy", busy, 0);
        fetch_en = 1'b0;
        reset_n = 1'b1;
        step();

        load_burst(4, 3, 32'hA1, 0, 0);
        for (int a = 4; a < 7; a++) fetch(a);

        load_burst(1022, 4, 32'h5000, 1, 0);
        fetch(1022);
        fetch(1023);
        fetch(0);
        fetch(1);

        fetch(5);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", instruction, 32'hA2);
            check("stall_valid", fetch_valid, 1);
        end

        load_burst(200, 2, 32'h7700, 0, 1);
        fetch(200);
        fetch(201);

        load_burst(4, 0, 32'hDEAD, 0, 0);
        fetch(4);

        load_burst(100, 8, 32'h1000, 0, 0);
        load_start = 1'b1;
        load_base = 10'd100;
        load_len = 11'd8;
        step();
        load_start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            load_valid = 1'b1;
            load_data = 32'h2000 + 32'(n);
            model[100 + n] = load_data;
            step();
        end
        load_valid = 1'b0;
        reset_n = 1'b0;
        step();
        check("abort_busy", busy, 0);
        check("abort_done", load_done, 0);
        check("abort_valid", fetch_valid, 0);
        check("abort_instr", instruction, 0);
        reset_n = 1'b1;
        step();
        check("abort_no_done", load_done, 0);
        check("abort_idle", busy, 0);
        for (int a = 100; a < 108; a++) fetch(a);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
